// File: rtl/tempo_step_sequencer.sv
// Tempo-locked step sequencer: a STEPS-entry pattern advanced on the selected tempo subdivision,
// driving note/trigger/gate to the voice datapath.
module tempo_step_sequencer #(
    parameter int unsigned STEPS      = 16,
    parameter int unsigned NOTE_WIDTH = 7,
    parameter int unsigned GATE_WIDTH = 16,
    localparam int unsigned SW        = $clog2(STEPS)
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic                  tick_quarter,
    input  logic                  tick_eighth,
    input  logic                  tick_sixteenth,
    input  logic [1:0]            division,
    input  logic                  start,
    input  logic                  stop,
    input  logic [SW-1:0]         loop_last,
    input  logic [GATE_WIDTH-1:0] gate_len,
    input  logic                  cfg_we,
    input  logic [SW-1:0]         cfg_addr,
    input  logic [NOTE_WIDTH-1:0] cfg_note,
    input  logic                  cfg_active,
    output logic [NOTE_WIDTH-1:0] note_out,
    output logic                  trigger,
    output logic                  gate,
    output logic [SW-1:0]         step_idx,
    output logic                  running
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StPlaying
    } state_e;

    state_e state_q, state_d;

    // Tick bits ordered {sixteenth, eighth, quarter}
    logic [2:0] tick_raw;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] prev_q, prev_d;
    logic [2:0] tick_rise;
    logic       step_pulse;

    logic [NOTE_WIDTH-1:0] note_mem_q [STEPS];
    logic [NOTE_WIDTH-1:0] note_mem_d [STEPS];
    logic [STEPS-1:0]      active_mem_q, active_mem_d;

    logic [NOTE_WIDTH-1:0] note_q, note_d;
    logic                  trig_q, trig_d;
    logic                  gate_q, gate_d;
    logic [SW-1:0]         step_q, step_d;
    logic [GATE_WIDTH-1:0] gcnt_q, gcnt_d;
    logic [SW-1:0]         step_next;

    assign tick_raw = {tick_sixteenth, tick_eighth, tick_quarter};

    always_comb begin
        sync1_d = tick_raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign tick_rise = sync2_q & ~prev_q;

    always_comb begin
        step_pulse = 1'b0;
        unique case (division)
            2'd0:    step_pulse = tick_rise[0];
            2'd1:    step_pulse = tick_rise[1];
            default: step_pulse = tick_rise[2];
        endcase
    end

    // Pattern writes land at the edge, so a play on that same edge still sees the old entry.
    always_comb begin
        note_mem_d   = note_mem_q;
        active_mem_d = active_mem_q;
        if (cfg_we) begin
            note_mem_d[cfg_addr]   = cfg_note;
            active_mem_d[cfg_addr] = cfg_active;
        end
    end

    always_comb begin
        if (state_q == StArmed) begin
            step_next = '0;
        end else if (step_q >= loop_last) begin
            step_next = '0;
        end else begin
            step_next = step_q + SW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        note_d  = note_q;
        trig_d  = 1'b0;
        gate_d  = gate_q;
        gcnt_d  = gcnt_q;

        // A high gate with a zero count is the hold-until-next-step mode.
        if (gate_q && (gcnt_q != '0)) begin
            gcnt_d = gcnt_q - GATE_WIDTH'(1);
            if (gcnt_q == GATE_WIDTH'(1)) begin
                gate_d = 1'b0;
            end
        end

        if (stop) begin
            state_d = StIdle;
            step_d  = '0;
            gate_d  = 1'b0;
            gcnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StArmed;
                    end
                end
                StArmed, StPlaying: begin
                    if (step_pulse) begin
                        state_d = StPlaying;
                        step_d  = step_next;
                        if (active_mem_q[step_next]) begin
                            note_d = note_mem_q[step_next];
                            trig_d = 1'b1;
                            gate_d = 1'b1;
                            gcnt_d = gate_len;
                        end else if (gate_len == '0) begin
                            gate_d = 1'b0;
                            gcnt_d = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            active_mem_q <= '0;
            note_q       <= '0;
            trig_q       <= 1'b0;
            gate_q       <= 1'b0;
            step_q       <= '0;
            gcnt_q       <= '0;
            for (int i = 0; i < int'(STEPS); i++) begin
                note_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            active_mem_q <= active_mem_d;
            note_q       <= note_d;
            trig_q       <= trig_d;
            gate_q       <= gate_d;
            step_q       <= step_d;
            gcnt_q       <= gcnt_d;
            for (int i = 0; i < int'(STEPS); i++) begin
                note_mem_q[i] <= note_mem_d[i];
            end
        end
    end

    assign note_out = note_q;
    assign trigger  = trig_q;
    assign gate     = gate_q;
    assign step_idx = step_q;
    assign running  = (state_q != StIdle);

endmodule

// File: tb/tb_tempo_step_sequencer.sv
// Bench for tempo_step_sequencer: per-feature scenarios plus randomized traffic, all checked
// against an event-level reference model of the sequencer.
module tb_tempo_step_sequencer;

    logic        clock_in = 1'b0;
    logic        reset_n;
    logic        tick_quarter, tick_eighth, tick_sixteenth;
    logic [1:0]  division;
    logic        start, stop;
    logic [3:0]  loop_last;
    logic [15:0] gate_len;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [6:0]  cfg_note;
    logic        cfg_active;
    logic [6:0]  note_out;
    logic        trigger, gate, running;
    logic [3:0]  step_idx;

    always #5 clock_in = ~clock_in;

    tempo_step_sequencer #(
        .STEPS      (16),
        .NOTE_WIDTH (7),
        .GATE_WIDTH (16)
    ) dut (
        .clock_in       (clock_in),
        .reset_n        (reset_n),
        .tick_quarter   (tick_quarter),
        .tick_eighth    (tick_eighth),
        .tick_sixteenth (tick_sixteenth),
        .division       (division),
        .start          (start),
        .stop           (stop),
        .loop_last      (loop_last),
        .gate_len       (gate_len),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_note       (cfg_note),
        .cfg_active     (cfg_active),
        .note_out       (note_out),
        .trigger        (trigger),
        .gate           (gate),
        .step_idx       (step_idx),
        .running        (running)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: playback state plus gate expressed as an end time or a hold flag.
    int         m_state;  // 0 idle, 1 armed, 2 playing
    logic [3:0] m_step;
    logic [6:0] m_note;
    logic       m_trig;
    bit         m_hold;
    longint     m_cyc = 0;
    longint     m_gate_end;
    logic [6:0] mem_note [16];
    logic       mem_act [16];
    bit         hq [4];
    bit         he [4];
    bit         hs [4];

    wire [13:0] dut_vec = {note_out, trigger, gate, step_idx, running};

    function automatic void model_reset();
        m_state = 0; m_step = '0; m_note = '0; m_trig = 1'b0;
        m_hold = 1'b0; m_gate_end = 0;
        for (int i = 0; i < 16; i++) begin
            mem_note[i] = '0; mem_act[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            hq[i] = 1'b0; he[i] = 1'b0; hs[i] = 1'b0;
        end
    endfunction

    function automatic bit m_gate();
        return m_hold || (m_cyc < m_gate_end);
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_note, m_trig, m_gate(), m_step, (m_state != 0)};
    endfunction

    // Outputs at edge n reflect a tick rise sampled at edges n-3 (low) and n-2 (high).
    function automatic void model_edge();
        bit pulse;
        logic [3:0] nxt;
        m_cyc++;
        for (int i = 3; i > 0; i--) begin
            hq[i] = hq[i-1]; he[i] = he[i-1]; hs[i] = hs[i-1];
        end
        hq[0] = tick_quarter; he[0] = tick_eighth; hs[0] = tick_sixteenth;
        if (division == 2'd0)      pulse = hq[2] && !hq[3];
        else if (division == 2'd1) pulse = he[2] && !he[3];
        else                       pulse = hs[2] && !hs[3];
        m_trig = 1'b0;
        if (stop) begin
            m_state = 0; m_step = '0; m_hold = 1'b0; m_gate_end = 0;
        end else if (m_state == 0) begin
            if (start) m_state = 1;
        end else if (pulse) begin
            if (m_state == 1 || m_step >= loop_last) nxt = 4'd0;
            else nxt = m_step + 4'd1;
            m_state = 2;
            m_step  = nxt;
            if (mem_act[nxt]) begin
                m_note = mem_note[nxt];
                m_trig = 1'b1;
                m_hold = (gate_len == 16'd0);
                m_gate_end = m_cyc + longint'(gate_len);
            end else if (gate_len == 16'd0) begin
                m_hold = 1'b0; m_gate_end = 0;
            end
        end
        if (cfg_we) begin
            mem_note[cfg_addr] = cfg_note;
            mem_act[cfg_addr]  = cfg_active;
        end
    endfunction

    task automatic cyc_step();
        @(posedge clock_in);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
        model_reset();
        total++;
        if (dut_vec !== 14'd0) begin
            bad++; $display("FAIL reset_state got=%h want=%h", dut_vec, 14'd0);
        end
        reset_n = 1'b1;
        cyc_step();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_idle got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_basic_play();
        logic [6:0] notes [4];
        logic [6:0] got_n [$];
        logic [3:0] got_s [$];
        int sent = 0, ph = 0, hi = 0, gate_cycles = 0;
        longint k_first = -1, trig_first = -1;
        notes[0] = 7'd60; notes[1] = 7'd62; notes[2] = 7'd64; notes[3] = 7'd65;
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_note = notes[i]; cfg_active = 1'b1;
            cyc_step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL basic_cfg got=%h want=%h", dut_vec, exp_vec());
            end
        end
        cfg_we = 1'b0;
        loop_last = 4'd3; division = 2'd2; gate_len = 16'd5; start = 1'b1;
        cyc_step();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL basic_start got=%h want=%h", dut_vec, exp_vec());
        end
        start = 1'b0;
        for (int c = 0; c < 130; c++) begin
            if (ph == 0 && sent < 6) begin
                sent++; ph = $urandom_range(8, 14); hi = 2;
                if (k_first < 0) k_first = m_cyc + 1;
            end
            tick_sixteenth = (hi > 0);
            if (hi > 0) hi--;
            if (ph > 0) ph--;
            cyc_step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL basic_cycle cyc=%0d got=%h want=%h", m_cyc, dut_vec,
                                exp_vec());
            end
            if (trigger) begin
                got_n.push_back(note_out); got_s.push_back(step_idx);
                if (trig_first < 0) trig_first = m_cyc;
            end
            if (gate) gate_cycles++;
        end
        tick_sixteenth = 1'b0;
        total++;
        if (got_n.size() != 6) begin
            bad++; $display("FAIL basic_trig_count got=%0d want=6", got_n.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (got_n[i] !== notes[i % 4] || got_s[i] !== 4'(i % 4)) begin
                    bad++; $display("FAIL basic_seq[%0d] got=%0d/%0d want=%0d/%0d", i, got_n[i],
                                    got_s[i], notes[i % 4], i % 4);
                end
            end
        end
        total++;
        if (trig_first - k_first != 2) begin
            bad++; $display("FAIL basic_latency got=%0d want=2", trig_first - k_first);
        end
        total++;
        if (gate_cycles != 30) begin
            bad++; $display("FAIL basic_gate_len got=%0d want=30", gate_cycles);
        end
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
    endtask

    task automatic test_division();
        int rises = 0, trigs = 0, run = 30;
        bit lvl = 1'b1, prevq = 1'b0;
        loop_last = 4'd3; gate_len = 16'd3; division = 2'd0; start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int c = 0; c < 260; c++) begin
            if (c >= 240) begin
                tick_quarter = 1'b0;
            end else begin
                tick_quarter = lvl;
                run--;
                if (run == 0) begin
                    lvl = !lvl; run = $urandom_range(1, 12);
                end
            end
            if (tick_quarter && !prevq) rises++;
            prevq = tick_quarter;
            tick_eighth    = 1'($urandom_range(0, 1));
            tick_sixteenth = 1'($urandom_range(0, 1));
            cyc_step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL division_cycle cyc=%0d got=%h want=%h", m_cyc, dut_vec,
                                exp_vec());
            end
            if (trigger) trigs++;
            if (c == 30) begin
                total++;
                if (trigs != 1) begin
                    bad++; $display("FAIL division_long_high got=%0d want=1", trigs);
                end
            end
        end
        total++;
        if (trigs != rises) begin
            bad++; $display("FAIL division_count got=%0d want=%0d", trigs, rises);
        end
        tick_eighth = 1'b0; tick_sixteenth = 1'b0;
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
    endtask

    task automatic test_hold();
        int trigs = 0;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_note = 7'd50; cfg_active = 1'b1;
        cyc_step();
        cfg_addr = 4'd1; cfg_note = 7'd77; cfg_active = 1'b0;
        cyc_step();
        cfg_we = 1'b0;
        gate_len = 16'd0; division = 2'd2; loop_last = 4'd3; start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int c = 0; c < 32; c++) begin
            tick_sixteenth = (c % 16 == 0);
            cyc_step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL hold_cycle cyc=%0d got=%h want=%h", m_cyc, dut_vec,
                                exp_vec());
            end
            if (trigger) trigs++;
            if (c == 15) begin
                total++;
                if ({gate, step_idx, 4'(trigs)} !== {1'b1, 4'd0, 4'd1}) begin
                    bad++; $display("FAIL hold_held got=%b/%0d/%0d want=1/0/1", gate, step_idx,
                                    trigs);
                end
            end
        end
        total++;
        if ({gate, step_idx, 4'(trigs)} !== {1'b0, 4'd1, 4'd1}) begin
            bad++; $display("FAIL hold_inactive got=%b/%0d/%0d want=0/1/1", gate, step_idx, trigs);
        end
        tick_sixteenth = 1'b0;
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
    endtask

    task automatic test_stop_start();
        bit found = 1'b0, trig_seen = 1'b0;
        logic [6:0] nseen = '0;
        start = 1'b1; stop = 1'b1;
        cyc_step();
        total++;
        if (running !== 1'b0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL stop_wins got=%b want=0", running);
        end
        stop = 1'b0;
        cyc_step();
        total++;
        if (running !== 1'b1) begin
            bad++; $display("FAIL start_arms got=%b want=1", running);
        end
        start = 1'b0; gate_len = 16'd0; division = 2'd2; loop_last = 4'd3;
        tick_sixteenth = 1'b1;
        for (int c = 0; c < 14; c++) begin
            cyc_step();
            tick_sixteenth = 1'b0;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL stop_play got=%h want=%h", dut_vec, exp_vec());
            end
            if (trigger) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL stop_first_play got=none want=trigger");
        end
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
        total++;
        if ({gate, trigger, step_idx, running, note_out} !== {1'b0, 1'b0, 4'd0, 1'b0, 7'd50}) begin
            bad++; $display("FAIL stop_outputs got=%b/%b/%0d/%b/%0d want=0/0/0/0/50", gate, trigger,
                            step_idx, running, note_out);
        end
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc_step();
            trig_seen |= trigger;
        end
        total++;
        if ({trig_seen, step_idx, running} !== {1'b0, 4'd0, 1'b1}) begin
            bad++; $display("FAIL restart_waits got=%b/%0d/%b want=0/0/1", trig_seen, step_idx,
                            running);
        end
        found = 1'b0;
        tick_sixteenth = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc_step();
            tick_sixteenth = 1'b0;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL restart_cycle got=%h want=%h", dut_vec, exp_vec());
            end
            if (trigger && !found) begin
                found = 1'b1; nseen = note_out;
            end
        end
        total++;
        if (!found || nseen !== 7'd50) begin
            bad++; $display("FAIL restart_step0 got=%b/%0d want=1/50", found, nseen);
        end
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
    endtask

    task automatic test_loop_shrink();
        logic [3:0] got_s [$];
        logic [3:0] want_s [12];
        int lowcnt = 0;
        bit first = 1'b0;
        for (int i = 0; i < 12; i++) want_s[i] = (i < 7) ? 4'(i) : 4'((i - 7) % 4);
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_note = 7'($urandom_range(0, 127));
            cfg_active = 1'b1;
            cyc_step();
        end
        cfg_we = 1'b0;
        loop_last = 4'd7; gate_len = 16'd100; division = 2'd2; start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int t = 0; t < 12; t++) begin
            for (int c = 0; c < 20; c++) begin
                tick_sixteenth = (c == 0);
                cyc_step();
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++; $display("FAIL shrink_cycle cyc=%0d got=%h want=%h", m_cyc, dut_vec,
                                    exp_vec());
                end
                if (first && !gate) lowcnt++;
                if (trigger) begin
                    got_s.push_back(step_idx); first = 1'b1;
                end
            end
            if (t == 6) loop_last = 4'd3;
        end
        tick_sixteenth = 1'b0;
        total++;
        if (lowcnt != 0) begin
            bad++; $display("FAIL shrink_gate_gap got=%0d want=0", lowcnt);
        end
        total++;
        if (got_s.size() != 12) begin
            bad++; $display("FAIL shrink_trig_count got=%0d want=12", got_s.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (got_s[i] !== want_s[i]) begin
                    bad++; $display("FAIL shrink_step[%0d] got=%0d want=%0d", i, got_s[i],
                                    want_s[i]);
                end
            end
        end
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
    endtask

    task automatic test_cfg_collision();
        logic [6:0] last_n = '0;
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_note = 7'(20 + i); cfg_active = 1'b1;
            cyc_step();
        end
        cfg_we = 1'b0;
        loop_last = 4'd3; gate_len = 16'd4; division = 2'd2; start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick_sixteenth = (c == 0);
            cyc_step();
        end
        tick_sixteenth = 1'b1;
        cyc_step();
        tick_sixteenth = 1'b0;
        cyc_step();
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_note = 7'd99; cfg_active = 1'b1;
        cyc_step();
        cfg_we = 1'b0;
        total++;
        if ({trigger, note_out, step_idx} !== {1'b1, 7'd21, 4'd1}) begin
            bad++; $display("FAIL collide_old got=%b/%0d/%0d want=1/21/1", trigger, note_out,
                            step_idx);
        end
        cyc_step();
        total++;
        if (note_out !== 7'd21) begin
            bad++; $display("FAIL collide_hold got=%0d want=21", note_out);
        end
        for (int c = 0; c < 40; c++) begin
            tick_sixteenth = (c % 10 == 0);
            cyc_step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL collide_cycle got=%h want=%h", dut_vec, exp_vec());
            end
            if (trigger) last_n = note_out;
        end
        tick_sixteenth = 1'b0;
        total++;
        if (last_n !== 7'd99) begin
            bad++; $display("FAIL collide_new got=%0d want=99", last_n);
        end
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 5) == 0) tick_quarter = ~tick_quarter;
            if ($urandom_range(0, 4) == 0) tick_eighth = ~tick_eighth;
            if ($urandom_range(0, 3) == 0) tick_sixteenth = ~tick_sixteenth;
            if ($urandom_range(0, 49) == 0) division = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) loop_last = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) gate_len = 16'($urandom_range(0, 12));
            cfg_we     = ($urandom_range(0, 4) == 0);
            cfg_addr   = 4'($urandom_range(0, 15));
            cfg_note   = 7'($urandom_range(0, 127));
            cfg_active = 1'($urandom_range(0, 1));
            cyc_step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random_cycle cyc=%0d got=%h want=%h", m_cyc, dut_vec,
                                exp_vec());
            end
        end
        tick_quarter = 1'b0; tick_eighth = 1'b0; tick_sixteenth = 1'b0;
        start = 1'b0; cfg_we = 1'b0; stop = 1'b1;
        cyc_step();
        stop = 1'b0;
    endtask

    task automatic test_reset_midplay();
        int trigs = 0;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_note = 7'd42; cfg_active = 1'b1;
        cyc_step();
        cfg_we = 1'b0;
        gate_len = 16'd0; division = 2'd2; loop_last = 4'd0; start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick_sixteenth = (c == 0);
            cyc_step();
        end
        tick_sixteenth = 1'b0;
        total++;
        if ({gate, running} !== 2'b11) begin
            bad++; $display("FAIL midplay_setup got=%b%b want=11", gate, running);
        end
        reset_n = 1'b0;
        #2;
        total++;
        if (dut_vec !== 14'd0) begin
            bad++; $display("FAIL reset_async got=%h want=%h", dut_vec, 14'd0);
        end
        model_reset();
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick_sixteenth = (c % 10 == 0);
            cyc_step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL midplay_cycle got=%h want=%h", dut_vec, exp_vec());
            end
            if (trigger) trigs++;
        end
        tick_sixteenth = 1'b0;
        total++;
        if (trigs != 0) begin
            bad++; $display("FAIL reset_cleared_pattern got=%0d want=0", trigs);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        tick_quarter = 1'b0; tick_eighth = 1'b0; tick_sixteenth = 1'b0;
        division = 2'd0; start = 1'b0; stop = 1'b0; loop_last = 4'd0; gate_len = 16'd0;
        cfg_we = 1'b0; cfg_addr = 4'd0; cfg_note = 7'd0; cfg_active = 1'b0;
        model_reset();
        test_reset();
        test_basic_play();
        test_division();
        test_hold();
        test_stop_start();
        test_loop_shrink();
        test_cfg_collision();
        test_random();
        test_reset_midplay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
